uart_tx_sched: RTL

//  Round-robin scheduler sharing one uart_tx serialiser among NUM_REQ byte producers
//  (TRNG sampler, status reporter, debug). Grants one requester, captures its byte,

---
 rtl/uart_tx_sched_pkg.sv | 13 +
 rtl/uart_tx_sched_if.sv | 18 +
 rtl/uart_tx_sched_rr_arbiter.sv | 24 ++
 rtl/uart_tx_sched.sv | 57 +++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared states, constants and index helper for the UART transmit scheduler
package uart_tx_sched_pkg;
  localparam int UART_FRAME_BITS = 10;
  localparam int DEF_TIMEOUT_CYCLES = 16384;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_START = 3'b010,
    ST_WAIT  = 3'b100
  } state_t;
  function automatic int rr_idx(input int last, input int step, input int n);
    return (last + step) % n;
  endfunction
endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: producer and uart_tx side signals of the transmit scheduler
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] req;
  logic [8*NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0] ack;
  logic tx_start;
  logic [7:0] tx_data;
  logic tx_busy;
  logic tx_done;
  logic [ID_W-1:0] grant_id;
  logic busy;
  logic err;
  modport master(output req, data, tx_busy, tx_done, input ack, tx_start, tx_data, grant_id, busy, err);
  modport slave(input req, data, tx_busy, tx_done, output ack, tx_start, tx_data, grant_id, busy, err);
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap
module rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    grant,
  output logic               any_req
);
  logic [ID_W-1:0] idx;
  // Walk from the farthest candidate back to last+1 so the nearest set request wins
  always_comb begin
    grant = last;
    idx = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ID_W'(rr_idx(32'(last), i, NUM_REQ));
      grant = req[idx] ? idx : grant;
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one uart_tx among several byte producers
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TIMEOUT_W = 15
) (
  input logic clk,
  input logic rst,
  uart_tx_sched_if.slave bus
);
  state_t state, state_nx;
  logic [ID_W-1:0] last, pick;
  logic [TIMEOUT_W-1:0] wd;
  logic any_req, grant_ok, timeout;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(bus.req),
    .last(last),
    .grant(pick),
    .any_req(any_req)
  );
  // uart_tx is not reset with us, so a frame still in flight must block the next grant
  assign grant_ok = any_req && !bus.tx_busy;
  assign timeout = wd == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE:  state_nx = grant_ok ? ST_START : ST_IDLE;
      ST_START: state_nx = ST_WAIT;
      ST_WAIT:  state_nx = (bus.tx_done || timeout) ? ST_IDLE : ST_WAIT;
      default:  state_nx = ST_IDLE;
    endcase
  end
  assign bus.tx_start = !rst && state == ST_START;
  assign bus.ack = bus.tx_start ? NUM_REQ'(1) << bus.grant_id : '0;
  assign bus.err = !rst && state == ST_WAIT && timeout && !bus.tx_done;
  assign bus.busy = !rst && state != ST_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      last <= ID_W'(NUM_REQ - 1);
      wd <= '0;
      bus.grant_id <= '0;
      bus.tx_data <= '0;
    end else begin
      state <= state_nx;
      wd <= state == ST_WAIT ? wd + 1'b1 : '0;
      if (state == ST_IDLE && grant_ok) begin
        bus.grant_id <= pick;
        last <= pick;
        bus.tx_data <= bus.data[8*pick +: 8];
      end
    end
  end
endmodule
